// File: rtl/alu_control_pipe.sv
// ALU-control stage for the pipelined RV32IM core.
// Decodes {funct7, ALU_Op, funct3} into an ALU operation code and registers it
// at the ID/EX boundary. MUL/DIV/REM ops hold the pipeline through a BUSY
// state until their latency has elapsed.
module alu_control_pipe #(
  parameter int ALU_OP_WIDTH = 4,
  parameter int MUL_LATENCY  = 3,
  parameter int DIV_LATENCY  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic [6:0]              funct7_i,
  input  logic [2:0]              alu_op_i,
  input  logic [2:0]              funct3_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic [ALU_OP_WIDTH-1:0] alu_operation_o,
  output logic                    valid_o,
  output logic                    illegal_o,
  output logic                    stall_o,
  output logic                    done_o
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

  // A latency of 1 behaves like any single-cycle op and never enters BUSY.
  localparam bit MUL_MULTI = (MUL_LATENCY >= 2);
  localparam bit DIV_MULTI = (DIV_LATENCY >= 2);

  // Counter preload is L-2: the accept edge and the completion edge are both
  // part of the L cycles.
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = MUL_MULTI ? CNT_W'(MUL_LATENCY - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = DIV_MULTI ? CNT_W'(DIV_LATENCY - 2) : '0;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LUI = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_BEQ = 4'd8;
  localparam logic [3:0] OP_BNE = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_DIV = 4'd13;
  localparam logic [3:0] OP_REM = 4'd14;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ALU_OP_WIDTH-1:0] op_q, op_d;
  logic                    valid_q, valid_d;
  logic                    illegal_q, illegal_d;
  logic                    done_q, done_d;

  logic [3:0]              dec_code;
  logic                    dec_illegal;
  logic                    dec_multi;
  logic [CNT_W-1:0]        dec_cnt_init;

  // Instruction decode: unrecognised encodings fall through to code 0 + illegal.
  always_comb begin
    dec_code     = OP_ADD;
    dec_illegal  = 1'b1;
    dec_multi    = 1'b0;
    dec_cnt_init = '0;
    unique case (alu_op_i)
      3'b000: begin
        if (funct7_i == F7_BASE) begin
          dec_illegal = 1'b0;
          case (funct3_i)
            3'b000:  dec_code = OP_ADD;
            3'b001:  dec_code = OP_SLL;
            3'b100:  dec_code = OP_XOR;
            3'b101:  dec_code = OP_SRL;
            3'b110:  dec_code = OP_OR;
            3'b111:  dec_code = OP_AND;
            default: dec_illegal = 1'b1;
          endcase
        end else if (funct7_i == F7_ALT) begin
          dec_illegal = 1'b0;
          case (funct3_i)
            3'b000:  dec_code = OP_SUB;
            3'b101:  dec_code = OP_SRA;
            default: dec_illegal = 1'b1;
          endcase
        end else if (funct7_i == F7_MEXT) begin
          dec_illegal = 1'b0;
          case (funct3_i)
            3'b000: begin
              dec_code     = OP_MUL;
              dec_multi    = MUL_MULTI;
              dec_cnt_init = MUL_CNT_INIT;
            end
            3'b100: begin
              dec_code     = OP_DIV;
              dec_multi    = DIV_MULTI;
              dec_cnt_init = DIV_CNT_INIT;
            end
            3'b110: begin
              dec_code     = OP_REM;
              dec_multi    = DIV_MULTI;
              dec_cnt_init = DIV_CNT_INIT;
            end
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      3'b001: begin
        dec_illegal = 1'b0;
        case (funct3_i)
          3'b000:  dec_code = OP_ADD;
          3'b100:  dec_code = OP_XOR;
          3'b110:  dec_code = OP_OR;
          3'b111:  dec_code = OP_AND;
          default: dec_illegal = 1'b1;
        endcase
      end
      3'b010: begin
        dec_code    = OP_LUI;
        dec_illegal = 1'b0;
      end
      3'b100: begin
        dec_code    = OP_ADD;
        dec_illegal = 1'b0;
      end
      3'b101: begin
        dec_illegal = 1'b0;
        case (funct3_i)
          3'b000:  dec_code = OP_BEQ;
          3'b001:  dec_code = OP_BNE;
          default: dec_illegal = 1'b1;
        endcase
      end
      3'b110: begin
        dec_code    = OP_JAL;
        dec_illegal = 1'b0;
      end
      3'b111: begin
        dec_code    = OP_ADD;
        dec_illegal = 1'b0;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal codes are always reported as 0.
    if (dec_illegal) begin
      dec_code     = OP_ADD;
      dec_multi    = 1'b0;
      dec_cnt_init = '0;
    end
  end

  // Next-state logic: flush beats stall, stall freezes everything else.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    done_d    = done_q;
    if (flush_i) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      done_d    = 1'b0;
    end else if (!stall_i) begin
      unique case (state_q)
        S_IDLE: begin
          done_d = 1'b0;
          if (valid_i) begin
            op_d      = ALU_OP_WIDTH'(dec_code);
            illegal_d = dec_illegal;
            if (dec_multi) begin
              valid_d = 1'b0;
              cnt_d   = dec_cnt_init;
              state_d = S_BUSY;
            end else begin
              valid_d = 1'b1;
            end
          end else begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
          end
        end
        S_BUSY: begin
          valid_d = 1'b0;
          done_d  = 1'b0;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  assign alu_operation_o = op_q;
  assign valid_o         = valid_q;
  assign illegal_o       = illegal_q;
  assign done_o          = done_q;
  assign stall_o         = (state_q == S_BUSY);

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe: decode table plus multi-cycle sequences.
module tb_alu_control_pipe;

  logic       clk;
  logic       reset;
  logic       valid_i;
  logic [6:0] funct7_i;
  logic [2:0] alu_op_i;
  logic [2:0] funct3_i;
  logic       stall_i;
  logic       flush_i;
  logic [3:0] alu_operation_o;
  logic       valid_o;
  logic       illegal_o;
  logic       stall_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

  alu_control_pipe #(
    .ALU_OP_WIDTH(4),
    .MUL_LATENCY (3),
    .DIV_LATENCY (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .funct7_i       (funct7_i),
    .alu_op_i       (alu_op_i),
    .funct3_i       (funct3_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .alu_operation_o(alu_operation_o),
    .valid_o        (valid_o),
    .illegal_o      (illegal_o),
    .stall_o        (stall_o),
    .done_o         (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] f7;
    logic [2:0] op;
    logic [2:0] f3;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] f7, input logic [2:0] op, input logic [2:0] f3);
    valid_i  = v;
    funct7_i = f7;
    alu_op_i = op;
    funct3_i = f3;
  endtask

  initial begin
    int done_cnt;
    int done_at;
    int stall_cnt;

    reset = 1'b0; valid_i = 1'b0; funct7_i = '0; alu_op_i = '0; funct3_i = '0;
    stall_i = 1'b0; flush_i = 1'b0;

    // Decode vectors applied back to back; each expects latency 1.
    vecs.push_back('{7'b0000000, 3'b000, 3'b000, 4'd0,  1'b0}); // ADD
    vecs.push_back('{7'b0100000, 3'b000, 3'b000, 4'd1,  1'b0}); // SUB
    vecs.push_back('{7'b0000000, 3'b000, 3'b001, 4'd6,  1'b0}); // SLL
    vecs.push_back('{7'b0000000, 3'b000, 3'b100, 4'd4,  1'b0}); // XOR
    vecs.push_back('{7'b0000000, 3'b000, 3'b101, 4'd7,  1'b0}); // SRL
    vecs.push_back('{7'b0000000, 3'b000, 3'b110, 4'd2,  1'b0}); // OR
    vecs.push_back('{7'b0000000, 3'b000, 3'b111, 4'd3,  1'b0}); // AND
    vecs.push_back('{7'b0000001, 3'b000, 3'b011, 4'd0,  1'b1}); // M-ext f3 011: illegal
    vecs.push_back('{7'b0100000, 3'b000, 3'b101, 4'd11, 1'b0}); // SRA
    vecs.push_back('{7'b0100000, 3'b000, 3'b111, 4'd0,  1'b1}); // alt funct7 with AND: illegal
    vecs.push_back('{7'b0000000, 3'b000, 3'b010, 4'd0,  1'b1}); // SLT not supported
    vecs.push_back('{7'b0000000, 3'b000, 3'b110, 4'd2,  1'b0}); // OR
    vecs.push_back('{7'b1000000, 3'b000, 3'b000, 4'd0,  1'b1}); // bad funct7
    vecs.push_back('{7'b1010101, 3'b001, 3'b000, 4'd0,  1'b0}); // ADDI, funct7 ignored
    vecs.push_back('{7'b1111111, 3'b001, 3'b110, 4'd2,  1'b0}); // ORI
    vecs.push_back('{7'b0100000, 3'b001, 3'b111, 4'd3,  1'b0}); // ANDI
    vecs.push_back('{7'b0000001, 3'b001, 3'b100, 4'd4,  1'b0}); // XORI (M funct7 ignored)
    vecs.push_back('{7'b1010101, 3'b010, 3'b011, 4'd5,  1'b0}); // LUI
    vecs.push_back('{7'b0000001, 3'b100, 3'b010, 4'd0,  1'b0}); // LW
    vecs.push_back('{7'b0100000, 3'b101, 3'b000, 4'd8,  1'b0}); // BEQ
    vecs.push_back('{7'b0000000, 3'b101, 3'b001, 4'd9,  1'b0}); // BNE
    vecs.push_back('{7'b0000000, 3'b101, 3'b100, 4'd0,  1'b1}); // unsupported branch
    vecs.push_back('{7'b1111111, 3'b110, 3'b101, 4'd10, 1'b0}); // JAL
    vecs.push_back('{7'b0000001, 3'b111, 3'b000, 4'd0,  1'b0}); // JALR (M funct7 ignored)
    vecs.push_back('{7'b0000000, 3'b011, 3'b000, 4'd0,  1'b1}); // ALU_Op 011: illegal
    vecs.push_back('{7'b0000000, 3'b110, 3'b000, 4'd10, 1'b0}); // JAL

    // Power-on reset.
    tick(); tick();
    chk("por_code", alu_operation_o, 0);
    chk("por_valid", valid_o, 0);
    chk("por_illegal", illegal_o, 0);
    chk("por_stall", stall_o, 0);
    chk("por_done", done_o, 0);
    reset = 1'b1;
    tick();

    // Get busy with a MUL, then assert reset mid-cycle.
    drive(1'b1, 7'b0000001, 3'b000, 3'b000);
    tick();
    chk("pre_rst_stall", stall_o, 1);
    chk("pre_rst_code", alu_operation_o, 12);
    valid_i = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_code", alu_operation_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_stall", stall_o, 0);
    chk("midrst_done", done_o, 0);
    #2 reset = 1'b1;
    tick();
    chk("post_rst_valid", valid_o, 0);
    $display("txn reset mid-BUSY: code=%0d valid=%0d stall=%0d", alu_operation_o, valid_o, stall_o);

    // ADD then SUB on consecutive cycles.
    drive(1'b1, 7'b0000000, 3'b000, 3'b000);
    tick();
    chk("add_code", alu_operation_o, 0);
    chk("add_valid", valid_o, 1);
    drive(1'b1, 7'b0100000, 3'b000, 3'b000);
    tick();
    chk("sub_code", alu_operation_o, 1);
    chk("sub_valid", valid_o, 1);
    $display("txn ADD,SUB: code=%0d valid=%0d", alu_operation_o, valid_o);
    valid_i = 1'b0;
    tick();
    chk("idle_valid", valid_o, 0);

    // Table-driven decode.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, vecs[i].f7, vecs[i].op, vecs[i].f3);
      tick();
      $display("txn vec %0d: f7=%b op=%b f3=%b -> code=%0d ill=%0d valid=%0d (exp code=%0d ill=%0d)",
               i, vecs[i].f7, vecs[i].op, vecs[i].f3, alu_operation_o, illegal_o, valid_o,
               vecs[i].code, vecs[i].ill);
      chk($sformatf("vec%0d_code", i), alu_operation_o, vecs[i].code);
      chk($sformatf("vec%0d_ill", i), illegal_o, vecs[i].ill);
      chk($sformatf("vec%0d_valid", i), valid_o, 1);
      chk($sformatf("vec%0d_stall", i), stall_o, 0);
    end
    valid_i = 1'b0;
    tick();
    chk("tbl_end_valid", valid_o, 0);

    // MUL, latency 3: accept at N, complete after N+2.
    drive(1'b1, 7'b0000001, 3'b000, 3'b000);
    tick();                                   // edge N
    chk("mul_n_stall", stall_o, 1);
    chk("mul_n_valid", valid_o, 0);
    chk("mul_n_done", done_o, 0);
    tick();                                   // edge N+1 (inputs held, ignored)
    chk("mul_n1_stall", stall_o, 1);
    chk("mul_n1_valid", valid_o, 0);
    tick();                                   // edge N+2
    chk("mul_n2_stall", stall_o, 0);
    chk("mul_n2_valid", valid_o, 1);
    chk("mul_n2_done", done_o, 1);
    chk("mul_n2_code", alu_operation_o, 12);
    chk("mul_n2_ill", illegal_o, 0);
    $display("txn MUL: code=%0d valid=%0d done=%0d", alu_operation_o, valid_o, done_o);
    // done_o holds through a stall and does not re-pulse on release.
    valid_i = 1'b0;
    stall_i = 1'b1;
    tick();
    chk("mul_stall_done_hold", done_o, 1);
    chk("mul_stall_valid_hold", valid_o, 1);
    stall_i = 1'b0;
    tick();
    chk("mul_release_done", done_o, 0);
    chk("mul_release_valid", valid_o, 0);

    // DIV aborted by flush three cycles after accept.
    drive(1'b1, 7'b0000001, 3'b000, 3'b100);
    tick();                                   // accept
    chk("divf_stall0", stall_o, 1);
    tick();
    tick();
    chk("divf_stall2", stall_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("divf_stall_drop", stall_o, 0);
    chk("divf_valid", valid_o, 0);
    chk("divf_done", done_o, 0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done_o || valid_o) done_cnt++;
    end
    chk("divf_no_done", done_cnt, 0);
    drive(1'b1, 7'b0000000, 3'b001, 3'b000);  // ADDI
    tick();
    chk("divf_addi_code", alu_operation_o, 0);
    chk("divf_addi_valid", valid_o, 1);
    $display("txn DIV flushed, ADDI: code=%0d valid=%0d", alu_operation_o, valid_o);
    valid_i = 1'b0;
    tick();

    // DIV with stall_i high for 4 cycles mid-count: completion at edge 7+4.
    drive(1'b1, 7'b0000001, 3'b000, 3'b100);
    tick();                                   // accept, edge 0
    valid_i = 1'b0;
    done_cnt  = 0;
    done_at   = -1;
    stall_cnt = 1;
    for (int k = 1; k <= 16; k++) begin
      stall_i = (k >= 3 && k <= 6);
      tick();
      if (stall_o) stall_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          chk("divs_code", alu_operation_o, 13);
          chk("divs_valid", valid_o, 1);
        end
      end
    end
    stall_i = 1'b0;
    chk("divs_done_edge", done_at, 11);
    chk("divs_done_pulses", done_cnt, 1);
    chk("divs_stall_cycles", stall_cnt, 11);
    $display("txn DIV stalled: done at edge %0d, pulses=%0d", done_at, done_cnt);

    // valid_i and flush_i together drop the instruction.
    drive(1'b1, 7'b0000000, 3'b101, 3'b001);  // BNE
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("bnef_valid", valid_o, 0);
    chk("bnef_stall", stall_o, 0);
    chk("bnef_ill", illegal_o, 0);
    tick();
    chk("bne_code", alu_operation_o, 9);
    chk("bne_valid", valid_o, 1);
    $display("txn BNE after flush: code=%0d valid=%0d", alu_operation_o, valid_o);
    valid_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
